// File: rtl/imem_responder_pkg.sv
// imem_responder_pkg: shared FSM state type and line geometry for the instruction responder.
package imem_responder_pkg;
    localparam int LINE_WORDS = 4;
    localparam int TAG_W = 28;
    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
endpackage

// File: rtl/imem_line_buf.sv
// imem_line_buf: single-entry instruction line buffer with word select.
module imem_line_buf
    import imem_responder_pkg::*;
(
    input  logic                        clock,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        wr,
    input  logic [TAG_W-1:0]            wr_tag,
    input  logic [LINE_WORDS*32-1:0]    wr_data,
    input  logic [1:0]                  sel,
    output logic                        valid,
    output logic [TAG_W-1:0]            tag,
    output logic [31:0]                 word
);
    logic [LINE_WORDS-1:0][31:0] data;

    // A flush outranks a simultaneous install so a cancelled fill never lands.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (clr) begin
            valid <= 1'b0;
        end else if (wr) begin
            valid <= 1'b1;
            tag   <= wr_tag;
            data  <= wr_data;
        end
    end

    assign word = data[sel];
endmodule

// File: rtl/imem_responder.sv
// imem_responder: zero-latency instruction fetch from a one-line buffer, refilled
// from backing memory on a miss; flushes during a fill drain the handshake first.
module imem_responder
    import imem_responder_pkg::*;
(
    input  logic                        clock,
    input  logic                        rst_n,
    input  logic [31:0]                 pc,
    input  logic                        flush,
    output logic [31:0]                 inst,
    output logic                        stall,
    output logic                        mem_req,
    output logic [31:0]                 mem_addr,
    input  logic                        mem_ack,
    input  logic [LINE_WORDS*32-1:0]    mem_rdata
);
    state_t state, next;
    logic [31:0] req_addr;
    logic valid, hit_line, hit, miss, unused_pc;
    logic [TAG_W-1:0] tag;
    logic [31:0] word;

    assign unused_pc = ^pc[1:0];
    assign hit_line  = valid && pc[31:4] == tag;
    assign hit       = state == IDLE && !flush && hit_line;
    assign miss      = state == IDLE && !flush && !hit_line;
    assign stall     = !hit;
    assign inst      = hit ? word : 32'h0;
    assign mem_addr  = mem_req ? req_addr : 32'h0;

    imem_line_buf u_buf (
        .clock   (clock),
        .rst_n   (rst_n),
        .clr     (flush),
        .wr      (state == REQ && mem_ack && !flush),
        .wr_tag  (req_addr[31:4]),
        .wr_data (mem_rdata),
        .sel     (pc[3:2]),
        .valid   (valid),
        .tag     (tag),
        .word    (word)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            req_addr <= '0;
        end else begin
            state <= next;
            if (miss) req_addr <= {pc[31:4], 4'b0};
        end
    end

    // Once a request is raised it stays up until acked, even across a flush.
    always_comb begin
        next    = state;
        mem_req = 1'b0;
        case (state)
            IDLE: next = miss ? REQ : IDLE;
            REQ: begin
                mem_req = 1'b1;
                next    = mem_ack ? IDLE : flush ? DROP : REQ;
            end
            DROP: begin
                mem_req = 1'b1;
                next    = mem_ack ? IDLE : DROP;
            end
            default: next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: per-cycle directed vectors plus a hand-written reset-mid-fill sequence.
module tb_imem_responder;
    logic clock = 0, rst_n = 0, flush = 0, mem_ack = 0, stall, mem_req;
    logic [31:0] pc = 0, inst, mem_addr;
    logic [127:0] mem_rdata = 0;
    int checks = 0, errors = 0;

    localparam logic [127:0] L0   = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    localparam logic [127:0] L100 = 128'h00000044_00000033_00000022_00000011;
    localparam logic [127:0] L110 = 128'h00000088_00000077_00000066_00000055;

    typedef struct {
        logic rst_n; logic [31:0] pc; logic flush; logic ack; logic [127:0] rdata;
        logic stall; logic [31:0] inst; logic req; logic [31:0] addr;
    } vec_t;
    vec_t q[$];

    imem_responder dut (
        .clock(clock), .rst_n(rst_n), .pc(pc), .flush(flush), .inst(inst), .stall(stall),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    task automatic v(input logic r, input logic [31:0] p, input logic f, input logic a,
                     input logic [127:0] d, input logic s, input logic [31:0] i,
                     input logic rq, input logic [31:0] ad);
        vec_t e;
        e.rst_n = r; e.pc = p; e.flush = f; e.ack = a; e.rdata = d;
        e.stall = s; e.inst = i; e.req = rq; e.addr = ad;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic outs(input int row, input logic s, input logic [31:0] i, input logic rq, input logic [31:0] ad);
        chk("stall", row, {31'b0, stall}, {31'b0, s});
        chk("inst", row, inst, i);
        chk("mem_req", row, {31'b0, mem_req}, {31'b0, rq});
        chk("mem_addr", row, mem_addr, ad);
    endtask

    initial begin
        //  rst pc          fl ack rdata  stall inst          req addr
        v(0, 32'h000, 0, 0, 0,    1, 32'h0,        0, 32'h000);
        v(1, 32'h000, 0, 0, 0,    1, 32'h0,        0, 32'h000);
        v(1, 32'h000, 0, 1, L0,   1, 32'h0,        1, 32'h000);
        v(1, 32'h000, 0, 0, 0,    0, 32'hA0A0A0A0, 0, 32'h000);
        v(1, 32'h008, 0, 0, 0,    0, 32'hA2A2A2A2, 0, 32'h000);
        v(1, 32'h100, 0, 0, 0,    1, 32'h0,        0, 32'h000);
        v(1, 32'h100, 0, 1, L100, 1, 32'h0,        1, 32'h100);
        v(1, 32'h100, 0, 0, 0,    0, 32'h11,       0, 32'h000);
        v(1, 32'h104, 0, 0, 0,    0, 32'h22,       0, 32'h000);
        v(1, 32'h108, 0, 0, 0,    0, 32'h33,       0, 32'h000);
        v(1, 32'h10C, 0, 0, 0,    0, 32'h44,       0, 32'h000);
        // delayed ack with a redirect attempt that must be ignored
        v(1, 32'h110, 0, 0, 0,    1, 32'h0,        0, 32'h000);
        for (int k = 0; k < 4; k++)
            v(1, 32'h200, 0, 0, L0, 1, 32'h0,      1, 32'h110);
        v(1, 32'h110, 0, 1, L110, 1, 32'h0,        1, 32'h110);
        v(1, 32'h114, 0, 0, 0,    0, 32'h66,       0, 32'h000);
        // flush into a pending fill, plus a second flush while draining
        v(1, 32'h100, 0, 0, 0,    1, 32'h0,        0, 32'h000);
        v(1, 32'h100, 0, 0, 0,    1, 32'h0,        1, 32'h100);
        v(1, 32'h100, 1, 0, 0,    1, 32'h0,        1, 32'h100);
        v(1, 32'h100, 0, 0, 0,    1, 32'h0,        1, 32'h100);
        v(1, 32'h100, 1, 0, 0,    1, 32'h0,        1, 32'h100);
        v(1, 32'h100, 0, 1, L100, 1, 32'h0,        1, 32'h100);
        v(1, 32'h100, 0, 0, 0,    1, 32'h0,        0, 32'h000);
        v(1, 32'h100, 0, 1, L100, 1, 32'h0,        1, 32'h100);
        v(1, 32'h10C, 0, 0, 0,    0, 32'h44,       0, 32'h000);
        // flush coincident with ack, then flush on a resident hit
        v(1, 32'h000, 0, 0, 0,    1, 32'h0,        0, 32'h000);
        v(1, 32'h000, 1, 1, L0,   1, 32'h0,        1, 32'h000);
        v(1, 32'h000, 0, 0, 0,    1, 32'h0,        0, 32'h000);
        v(1, 32'h000, 0, 1, L0,   1, 32'h0,        1, 32'h000);
        v(1, 32'h004, 0, 0, 0,    0, 32'hA1A1A1A1, 0, 32'h000);
        v(1, 32'h004, 1, 0, 0,    1, 32'h0,        0, 32'h000);
        v(1, 32'h004, 0, 0, 0,    1, 32'h0,        0, 32'h000);
        v(1, 32'h004, 0, 1, L0,   1, 32'h0,        1, 32'h000);
        v(1, 32'h00C, 0, 0, 0,    0, 32'hA3A3A3A3, 0, 32'h000);
        // ack while idle is ignored
        v(1, 32'h00C, 0, 1, L100, 0, 32'hA3A3A3A3, 0, 32'h000);
        v(1, 32'h00C, 0, 0, 0,    0, 32'hA3A3A3A3, 0, 32'h000);

        foreach (q[k]) begin
            @(negedge clock);
            rst_n = q[k].rst_n; pc = q[k].pc; flush = q[k].flush;
            mem_ack = q[k].ack; mem_rdata = q[k].rdata;
            #1 outs(k, q[k].stall, q[k].inst, q[k].req, q[k].addr);
        end

        // reset asserted while a fill is outstanding
        @(negedge clock); pc = 32'h100; mem_ack = 0; mem_rdata = 0;
        #1 outs(100, 1, 32'h0, 0, 32'h0);
        @(negedge clock);
        #1 outs(101, 1, 32'h0, 1, 32'h100);
        #1 rst_n = 0;
        #1 outs(102, 1, 32'h0, 0, 32'h0);
        @(negedge clock); rst_n = 1; pc = 32'h00C;
        #1 outs(103, 1, 32'h0, 0, 32'h0);
        @(negedge clock); mem_ack = 1; mem_rdata = L0;
        #1 outs(104, 1, 32'h0, 1, 32'h0);
        @(negedge clock); mem_ack = 0; mem_rdata = 0; pc = 32'h008;
        #1 outs(105, 0, 32'hA2A2A2A2, 0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameters: none; line size fixed at 4 words (128 bits), single line entry.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 pc  input  32  fetch address from the fetch stage PC register; bits [1:0] ignored.
REQ-005 flush  input  1  invalidate line buffer; cancels the pending fill's install.
REQ-006 inst  output  32  instruction word returned to the fetch/decode pipe register.
REQ-007 stall  output  1  high = inst not valid this cycle; fetch holds PC and the pipe enable.
REQ-008 mem_req  output  1  line read request to backing memory.
REQ-009 mem_addr  output  32  line-aligned request address, bits [3:0] = 0.
REQ-010 mem_ack  input  1  backing memory: mem_rdata valid this cycle, request accepted.
REQ-011 mem_rdata  input  128  returned line; word k in bits [32k+31:32k].

Function
REQ-012 Line buffer state: valid bit, 28-bit tag, 128-bit data.
REQ-013 Hit = valid and pc[31:4] == tag and state IDLE and flush low; combinational, same cycle.
REQ-014 On hit: inst = data word pc[3:2], stall = 0, zero-cycle latency.
REQ-015 FSM states: IDLE, REQ, DROP.
REQ-016 IDLE, miss (not hit, flush low): stall = 1; latch req_addr = {pc[31:4],4'b0}; next REQ.
REQ-017 IDLE, flush high: valid cleared; stall = 1; state stays IDLE.
REQ-018 REQ: mem_req = 1, mem_addr = req_addr, both held stable until mem_ack; stall = 1.
REQ-019 REQ with mem_ack high and flush low: data <= mem_rdata, tag <= req_addr[31:4], valid <= 1; next IDLE.
REQ-020 REQ with flush high, no ack: next DROP; mem_req stays high (handshake never abandoned).
REQ-021 REQ with flush and mem_ack in the same cycle: line discarded, valid <= 0; next IDLE.
REQ-022 DROP: mem_req = 1, same address; on mem_ack, data discarded, valid stays 0; next IDLE; stall = 1.
REQ-023 Further flush in DROP: no effect beyond keeping valid 0.
REQ-024 Minimum miss penalty: 2 stalled cycles (IDLE miss, REQ with immediate ack); hit on the 3rd cycle.
REQ-025 mem_req low in IDLE; mem_ack in IDLE or when not requesting is ignored.
REQ-026 inst = 32'h0 whenever stall = 1.
REQ-027 pc change while stall is high (redirect) is only accepted in IDLE; the fill address is req_addr, not live pc.

Reset
REQ-028 rst_n low: state IDLE, valid 0, tag 0, data 0, req_addr 0, immediately and asynchronously.
REQ-029 Reset outputs: mem_req 0, mem_addr 0, inst 0; stall = 1 after reset release until the first hit.
REQ-030 Reset mid-fill: request dropped without waiting for mem_ack; backing memory must tolerate this.

Structure
REQ-031 Shared package holds the FSM state enum (IDLE, REQ, DROP) and the constants LINE_WORDS = 4 and TAG_W = 28.
REQ-032 One sub-module: imem_line_buf (valid, tag, data registers with word select); FSM in top.

Verification
REQ-033 Reset, pc = 0x00000000, mem_ack returned 1 cycle after mem_req -> mem_addr 0x0, stall 2 cycles, then inst = mem_rdata[31:0].
REQ-034 Line 0x100 = {0x44,0x33,0x22,0x11} (word3..0); pc steps 0x100, 0x104, 0x108, 0x10C -> one miss, then 4 consecutive hits 0x11, 0x22, 0x33, 0x44, stall 0.
REQ-035 pc 0x10C to 0x110 -> miss, mem_addr 0x110, mem_ack delayed 5 cycles -> mem_req/mem_addr held stable, stall high for 6 cycles.
REQ-036 Flush 2 cycles into a pending fill -> DROP, fill discarded on ack, re-request of same pc issued, valid set only after the second ack.
REQ-037 Flush coincident with mem_ack -> valid 0, IDLE next, re-request follows; hit to a resident line with flush high -> stall 1, valid cleared.
REQ-038 rst_n pulled low while in REQ -> mem_req 0 immediately, state IDLE, valid 0; pc 0x0 re-requested after release.
